d_pipe_reg: RTL
===============

// Module: d_pipe_reg
// PURPOSE
//  F->D pipeline register of the P7 MIPS core. Captures fetch outputs (PC, instruction, fetch exception
//  code, delay-slot flag) each cycle and presents them to the decode stage. Implements stall (hold),
//  flush (bubble that keeps PC), and interrupt/exception request (bubble at handler PC).
//  Sanitises faulted fetches so decode never sees a garbage instruction.
// PARAMETERS
//  RESET_PC    32'h0000_3000  PC_D value after reset
//  HANDLER_PC  32'h0000_4180  PC_D value loaded on req
//  EXC_W       5              width of exception code fields
// PORTS
//  clk         in   1      system clock, all state updates on posedge
//  reset       in   1      synchronous, active-high reset
//  req         in   1      exception/interrupt taken this cycle (from CP0); highest non-reset priority
//  stall       in   1      hazard stall: hold all D-stage contents
//  flush       in   1      discard incoming F instruction (eret in D); ignored while stall=1
//  PC_F        in   32     fetch PC
//  instr_F     in   32     instruction word read at PC_F
//  F_excCode   in   EXC_W  fetch exception code (0 = none, `ADEL = bad fetch address)
//  BD_F        in   1      fetched instruction is in a branch delay slot
//  PC_D        out  32     decode PC
//  instr_D     out  32     decode instruction (0 = nop)
//  D_excCode   out  EXC_W  exception code carried into decode
//  BD_D        out  1      delay-slot flag for decode
//  valid_D     out  1      1 = D holds a real instruction, 0 = bubble
// BEHAVIOUR
//  - All outputs are direct register outputs; 1-cycle latency F->D; no combinational paths in->out.
//  - Per posedge, first matching row wins:
//     1 reset           : PC_D=RESET_PC, instr_D=0, D_excCode=0, BD_D=0, valid_D=0
//     2 req             : PC_D=HANDLER_PC, instr_D=0, D_excCode=0, BD_D=0, valid_D=0 (overrides stall/flush)
//     3 stall           : all registers hold (flush ignored)
//     4 flush           : PC_D=PC_F, instr_D=0, D_excCode=0, BD_D=BD_F, valid_D=0 (macro-PC kept)
//     5 load            : PC_D=PC_F, BD_D=BD_F, valid_D=1, D_excCode=F_excCode,
//                         instr_D = (F_excCode!=0) ? 0 : instr_F
//  - Faulted fetch: F_excCode nonzero -> instruction zeroed, code forwarded, valid_D still 1 so CP0
//    sees the fault with correct PC_D/BD_D.
//  - A bubble always has D_excCode=0; no exception can originate from a bubble.
//  - Reset mid-stall or mid-req: reset wins unconditionally; stall and req are don't-care that cycle.
//  - stall and req both high: req wins (the stalled instruction is squashed, re-fetched after eret).
//  - Stall held for N cycles: outputs frozen N cycles; first cycle after stall drops loads current F.
//  - No internal state beyond the five output registers; no FSM.
// STRUCTURE
//  - Exception codes (`ADEL etc.) and HANDLER_PC/RESET_PC defaults come from shared const.v; do not
//    redefine locally.
//  - Single flat module; the next-state mux is a single priority always block. No sub-modules.
// TESTING
//  1 reset=1 one cycle -> PC_D=0x3000, instr_D=0, valid_D=0, D_excCode=0, BD_D=0.
//  2 PC_F=0x3004, instr_F=0x24010005, no stall -> next cycle PC_D=0x3004, instr_D=0x24010005, valid_D=1.
//  3 stall=1 for 3 cycles while PC_F walks 0x3008..0x3010 -> PC_D stays 0x3004 all 3 cycles;
//    stall drops with PC_F=0x3010 -> PC_D=0x3010 next cycle.
//  4 PC_F=0x3002, F_excCode=`ADEL, instr_F=0xFFFFFFFF -> instr_D=0, D_excCode=`ADEL, PC_D=0x3002, valid_D=1.
//  5 flush=1, PC_F=0x3020, BD_F=1 -> PC_D=0x3020, instr_D=0, valid_D=0, BD_D=1; same with stall=1 -> hold.
//  6 req=1 with stall=1 and flush=1 -> PC_D=0x4180, instr_D=0, valid_D=0; req+reset same cycle -> PC_D=0x3000.

Source files
------------

// File: rtl/d_pipe_reg_pkg.sv
// Shared constants for the P7 core front end: reset/handler vectors, exception codes,
// and the helper that sanitises a fetched instruction word.
package d_pipe_reg_pkg;

    localparam int          EXC_W_DEF      = 5;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

    // MIPS CP0 Cause.ExcCode values
    localparam logic [EXC_W_DEF-1:0] EXC_NONE = 5'd0;
    localparam logic [EXC_W_DEF-1:0] EXC_ADEL = 5'd4;
    localparam logic [EXC_W_DEF-1:0] EXC_ADES = 5'd5;
    localparam logic [EXC_W_DEF-1:0] EXC_RI   = 5'd10;
    localparam logic [EXC_W_DEF-1:0] EXC_OV   = 5'd12;

    // A faulted fetch read garbage; decode must see a nop instead.
    function automatic logic [31:0] fetch_instr(input logic [31:0] instr, input logic faulted);
        return faulted ? NOP_INSTR : instr;
    endfunction

endpackage

// File: rtl/d_pipe_reg.sv
// F->D pipeline register: captures fetch outputs each cycle and applies
// reset > req > stall > flush > load priority. All outputs come straight from flops.
module d_pipe_reg
    import d_pipe_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
    parameter int          EXC_W      = EXC_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      PC_F,
    input  logic [31:0]      instr_F,
    input  logic [EXC_W-1:0] F_excCode,
    input  logic             BD_F,
    output logic [31:0]      PC_D,
    output logic [31:0]      instr_D,
    output logic [EXC_W-1:0] D_excCode,
    output logic             BD_D,
    output logic             valid_D
);

    logic f_faulted;
    assign f_faulted = (F_excCode != '0);

    // Bubbles always carry a zero exception code so nothing can fault out of one.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC_D      <= RESET_PC;
            instr_D   <= NOP_INSTR;
            D_excCode <= '0;
            BD_D      <= 1'b0;
            valid_D   <= 1'b0;
        end else if (req) begin
            PC_D      <= HANDLER_PC;
            instr_D   <= NOP_INSTR;
            D_excCode <= '0;
            BD_D      <= 1'b0;
            valid_D   <= 1'b0;
        end else if (stall) begin
            PC_D      <= PC_D;
            instr_D   <= instr_D;
            D_excCode <= D_excCode;
            BD_D      <= BD_D;
            valid_D   <= valid_D;
        end else if (flush) begin
            PC_D      <= PC_F;
            instr_D   <= NOP_INSTR;
            D_excCode <= '0;
            BD_D      <= BD_F;
            valid_D   <= 1'b0;
        end else begin
            PC_D      <= PC_F;
            instr_D   <= fetch_instr(instr_F, f_faulted);
            D_excCode <= F_excCode;
            BD_D      <= BD_F;
            valid_D   <= 1'b1;
        end
    end

endmodule
